// File: rtl/led_stage_indicator_if.sv
// Stage-indicator bundle: game-state inputs toward the LED driver and the
// LED drive / busy flag back. master = game logic side, slave = LED driver.
interface led_stage_indicator_if #(
  parameter int NUM_LEDS = 10,
  parameter int STAGE_W  = 32,
  parameter int PWM_W    = 4
);
  logic [STAGE_W-1:0]  stage;
  logic [1:0]          mode;
  logic                game_over;
  logic [PWM_W-1:0]    brightness;
  logic [NUM_LEDS-1:0] led_control;
  logic                busy;

  modport master (
    output stage, mode, game_over, brightness,
    input  led_control, busy
  );

  modport slave (
    input  stage, mode, game_over, brightness,
    output led_control, busy
  );
endinterface

// File: rtl/led_stage_indicator.sv
// Stage-to-LED bar driver with display modes, level-up blink, game-over
// flash and PWM dimming.
// Ports: clk, resetN (sync, active-low), io (slave): stage, mode,
//   game_over, brightness in; led_control, busy out (both registered).
module led_stage_indicator #(
  parameter int NUM_LEDS     = 10,
  parameter int STAGE_W      = 32,
  parameter int BLINK_DIV    = 12500000,
  parameter int FLASH_BLINKS = 3,
  parameter int PWM_W        = 4
) (
  input logic                   clk,
  input logic                   resetN,
  led_stage_indicator_if.slave  io
);

  localparam int CW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HALVES = 2 * FLASH_BLINKS;
  localparam int HW     = $clog2(HALVES);
  localparam int SW     = $clog2(NUM_LEDS);

  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALVES - 1);
  localparam logic [SW-1:0] S_MAX      = SW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    SHOW      = 2'd0,
    CELEBRATE = 2'd1,
    GAMEOVER  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                busy_q, busy_d;
  logic [STAGE_W-1:0]  stage_q;
  logic                primed_q;
  logic [PWM_W-1:0]    pwm_cnt_q;
  logic [CW-1:0]       blink_q, blink_d;
  logic [HW-1:0]       half_q, half_d;
  logic                phase_q, phase_d;

  logic [SW-1:0]       s;
  logic [NUM_LEDS-1:0] pat;
  logic [NUM_LEDS-1:0] pat_g;
  logic                pwm_on;
  logic                levelup;
  logic                tick;

  // Clamp on the full-width stage so large values never alias.
  always_comb begin
    if (io.stage > STAGE_W'(NUM_LEDS - 1)) begin
      s = S_MAX;
    end else begin
      s = io.stage[SW-1:0];
    end
  end

  always_comb begin
    pat = '0;
    unique case (io.mode)
      2'd0: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          pat[i] = (SW'(i) <= s);
        end
      end
      2'd1: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          pat[i] = (SW'(i) == s);
        end
      end
      2'd2: pat = NUM_LEDS'(io.stage);
      default: pat = '0;
    endcase
  end

  assign pwm_on  = (&io.brightness) || (pwm_cnt_q < io.brightness);
  assign pat_g   = pwm_on ? pat : '0;
  assign levelup = primed_q && (io.stage > stage_q);
  assign tick    = (blink_q == BLINK_LAST);

  always_comb begin
    state_d = state_q;
    blink_d = tick ? '0 : blink_q + 1'b1;
    phase_d = tick ? ~phase_q : phase_q;
    half_d  = half_q;
    if (io.game_over) begin
      state_d = GAMEOVER;
      half_d  = '0;
      if (state_q != GAMEOVER) begin
        blink_d = '0;
        phase_d = 1'b1;
      end
    end else if (state_q == GAMEOVER) begin
      // Leaving game-over never celebrates, even on a rising stage.
      state_d = SHOW;
      blink_d = '0;
      phase_d = 1'b0;
      half_d  = '0;
    end else if (levelup) begin
      // Entry and retrigger both restart the blink sequence.
      state_d = CELEBRATE;
      blink_d = '0;
      phase_d = 1'b0;
      half_d  = '0;
    end else if (state_q == CELEBRATE) begin
      if (tick) begin
        half_d = half_q + 1'b1;
        if (half_q == HALF_LAST) begin
          state_d = SHOW;
          blink_d = '0;
          phase_d = 1'b0;
          half_d  = '0;
        end
      end
    end else begin
      blink_d = '0;
      phase_d = 1'b0;
      half_d  = '0;
    end
  end

  // Output reflects the state and phase being entered this edge.
  always_comb begin
    led_d = pat_g;
    unique case (state_d)
      CELEBRATE: led_d = phase_d ? pat_g : '0;
      GAMEOVER:  led_d = (phase_d && pwm_on) ? '1 : '0;
      default:   led_d = pat_g;
    endcase
    busy_d = (state_d != SHOW);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= SHOW;
      led_q     <= '1;
      busy_q    <= 1'b0;
      stage_q   <= '0;
      primed_q  <= 1'b0;
      pwm_cnt_q <= '0;
      blink_q   <= '0;
      half_q    <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      stage_q   <= io.stage;
      primed_q  <= 1'b1;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      blink_q   <= blink_d;
      half_q    <= half_d;
      phase_q   <= phase_d;
    end
  end

  assign io.led_control = led_q;
  assign io.busy        = busy_q;

endmodule
